hw_mutex_rr_arbiter: RTL and testbench
======================================

// Module: hw_mutex_rr_arbiter
// PURPOSE
//  Round-robin hardware mutex for the event unit. Owns one lock shared by NB_CORES event_unit_core
//  instances. Lock/unlock requests arrive per core; the block tracks pending requesters, grants
//  fairly, passes a message word from unlocker to the next owner, and pulses a per-core event line
//  into the cluster event map.
// PARAMETERS
//  NB_CORES     8   number of requesting cores (>=2); OWNER_W = $clog2(NB_CORES)
//  MUTEX_MSG_W  32  width of the message word handed over on unlock
// PORTS
//  clk_i            in   1             clock
//  rst_ni           in   1             reset, asynchronous, active-low
//  lock_req_i       in   NB_CORES      1-cycle pulse per core: request the lock
//  unlock_req_i     in   NB_CORES      1-cycle pulse per core: release the lock
//  msg_wdata_i      in   MUTEX_MSG_W   message, sampled only on a valid unlock
//  msg_rdata_o      out  MUTEX_MSG_W   last message written (registered)
//  mutex_event_o    out  NB_CORES      1-cycle grant pulse to the new owner (registered)
//  locked_o         out  1             lock currently held
//  owner_o          out  OWNER_W       current owner index, valid while locked_o
//  pending_o        out  NB_CORES      registered pending-request vector
// BEHAVIOUR
//  - Reset (async): state FREE, locked_o=0, owner_o=0, rr_ptr=0, pending_o=0, mutex_event_o=0,
//    msg_rdata_o=0. Reset mid-operation drops the owner and all pending requests; no event pulses.
//  - States: FREE, LOCKED. All outputs are flops; no combinational input->output paths.
//  - Pending: pending_q[i] is set on lock_req_i[i] and cleared when core i is granted.
//    lock_req_i[i] while already pending is a no-op. lock_req_i[owner] while LOCKED is ignored
//    unless it coincides with that owner's valid unlock (see below).
//  - Candidates in cycle t: cand = pending_q | lock_req_i, with the owner's bit masked while LOCKED.
//  - Arbitration: first set bit of cand searching upward from rr_ptr, wrapping NB_CORES-1 -> 0.
//    On a grant to core w: rr_ptr <= (w+1) mod NB_CORES.
//  - FREE, cand != 0 in cycle t: at t+1 state=LOCKED, owner_o=w, mutex_event_o=onehot(w) for
//    exactly one cycle, pending_q[w]=0. Latency lock_req -> event = 1 cycle.
//  - LOCKED, unlock_req_i[owner] in cycle t: msg_q <= msg_wdata_i (visible at t+1). If cand != 0,
//    direct handover: at t+1 owner_o=w, mutex_event_o=onehot(w), state stays LOCKED (locked_o never
//    drops). If cand == 0: at t+1 state=FREE, locked_o=0, no event.
//  - An owner pulsing lock_req and unlock_req in the same cycle releases the lock and is recorded
//    as pending from t+1; it is not a candidate in cycle t.
//  - unlock_req_i from a non-owner, or any unlock_req_i while FREE: ignored; msg_q unchanged.
//    Multiple unlock bits in one cycle: only the owner's bit is evaluated.
//  - At most one mutex_event_o bit is high in any cycle; the grant pulse never repeats for the
//    same grant.
//  - owner_o holds its last value after release (don't-care while FREE; checkers gate on locked_o).
// TESTING
//  1 Reset release, no stimulus -> locked_o=0, pending_o=0, msg_rdata_o=0, mutex_event_o=0.
//  2 Idle, lock_req_i=8'h08 at t -> t+1: mutex_event_o=8'h08 for 1 cycle, owner_o=3, locked_o=1,
//    rr_ptr=4.
//  3 Owner 3, lock_req_i=8'h62 (cores 1,5,6) -> pending_o=8'h62. Three successive owner unlocks
//    hand over 5, then 6, then 1, each event one cycle after its unlock; locked_o stays 1.
//  4 Owner 1, nothing pending, unlock_req_i=8'h02 with msg 32'hDEADBEEF -> t+1: locked_o=0,
//    msg_rdata_o=32'hDEADBEEF. A subsequent lock by core 0 sees the same message.
//  5 Owner 2: unlock_req_i=8'h10 (non-owner) and lock_req_i=8'h04 (owner) -> no state change, no
//    event, msg unchanged. Then unlock+lock from core 2 in the same cycle, nothing else pending ->
//    FREE at t+1, re-grant to core 2 at t+2.
//  6 Locked with pending_o=8'hF0, assert rst_ni low mid-cycle -> all outputs immediately at reset
//    values; after release, no stale grants occur.

Source files
------------

// File: rtl/hw_mutex_rr_arbiter.sv
// Round-robin hardware mutex: tracks pending lock requests, grants one owner at a time,
// hands a message word from the releasing owner to the next, and pulses a grant event.
module hw_mutex_rr_arbiter #(
    parameter int unsigned NB_CORES    = 8,
    parameter int unsigned MUTEX_MSG_W = 32,
    localparam int unsigned OWNER_W    = $clog2(NB_CORES)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NB_CORES-1:0]    lock_req_i,
    input  logic [NB_CORES-1:0]    unlock_req_i,
    input  logic [MUTEX_MSG_W-1:0] msg_wdata_i,
    output logic [MUTEX_MSG_W-1:0] msg_rdata_o,
    output logic [NB_CORES-1:0]    mutex_event_o,
    output logic                   locked_o,
    output logic [OWNER_W-1:0]     owner_o,
    output logic [NB_CORES-1:0]    pending_o
);

    typedef enum logic {FREE, LOCKED} state_e;

    state_e                 state_q, state_d;
    logic [OWNER_W-1:0]     owner_q, owner_d;
    logic [OWNER_W-1:0]     rr_q, rr_d;
    logic [MUTEX_MSG_W-1:0] msg_q, msg_d;
    logic [NB_CORES-1:0]    event_q, event_d;
    logic [NB_CORES-1:0]    pending_q, pending_d;

    logic [NB_CORES-1:0]    owner_mask;
    logic [NB_CORES-1:0]    cand;
    logic [NB_CORES-1:0]    new_req;
    logic                   owner_unlock;
    logic                   grant;
    logic [OWNER_W-1:0]     win;
    int unsigned            idx;

    always_comb begin
        owner_mask   = '0;
        owner_unlock = 1'b0;
        if (state_q == LOCKED) begin
            owner_mask   = NB_CORES'(1) << owner_q;
            owner_unlock = unlock_req_i[owner_q];
        end
        cand    = (pending_q | lock_req_i) & ~owner_mask;
        // An owner's own request only counts when it releases in the same cycle
        new_req = lock_req_i & ~(owner_unlock ? '0 : owner_mask);

        // Scan from the far end so the closest set bit at or after rr_q wins last
        win = '0;
        idx = 0;
        for (int unsigned k = 0; k < NB_CORES; k++) begin
            idx = 32'(rr_q) + (NB_CORES - 1 - k);
            if (idx >= NB_CORES) idx = idx - NB_CORES;
            if (cand[idx[OWNER_W-1:0]]) win = idx[OWNER_W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        msg_d     = msg_q;
        event_d   = '0;
        pending_d = pending_q | new_req;
        grant     = 1'b0;

        case (state_q)
            FREE: begin
                if (|cand) grant = 1'b1;
            end
            LOCKED: begin
                if (owner_unlock) begin
                    msg_d = msg_wdata_i;
                    if (|cand) grant = 1'b1;
                    else       state_d = FREE;
                end
            end
            default: state_d = FREE;
        endcase

        if (grant) begin
            state_d   = LOCKED;
            owner_d   = win;
            rr_d      = (win == OWNER_W'(NB_CORES - 1)) ? '0 : win + OWNER_W'(1);
            event_d   = NB_CORES'(1) << win;
            pending_d = pending_d & ~(NB_CORES'(1) << win);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= FREE;
            owner_q   <= '0;
            rr_q      <= '0;
            msg_q     <= '0;
            event_q   <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            msg_q     <= msg_d;
            event_q   <= event_d;
            pending_q <= pending_d;
        end
    end

    assign msg_rdata_o   = msg_q;
    assign mutex_event_o = event_q;
    assign locked_o      = (state_q == LOCKED);
    assign owner_o       = owner_q;
    assign pending_o     = pending_q;

endmodule

// File: tb/tb_hw_mutex_rr_arbiter.sv
// Bench for hw_mutex_rr_arbiter: directed scenarios then random traffic, each cycle compared
// against a behavioural lock model kept as plain arrays.
module tb_hw_mutex_rr_arbiter;

    localparam int NB = 8;
    localparam int MW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [NB-1:0] lock_req_i;
    logic [NB-1:0] unlock_req_i;
    logic [MW-1:0] msg_wdata_i;
    logic [MW-1:0] msg_rdata_o;
    logic [NB-1:0] mutex_event_o;
    logic          locked_o;
    logic [2:0]    owner_o;
    logic [NB-1:0] pending_o;

    hw_mutex_rr_arbiter #(.NB_CORES(NB), .MUTEX_MSG_W(MW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .lock_req_i   (lock_req_i),
        .unlock_req_i (unlock_req_i),
        .msg_wdata_i  (msg_wdata_i),
        .msg_rdata_o  (msg_rdata_o),
        .mutex_event_o(mutex_event_o),
        .locked_o     (locked_o),
        .owner_o      (owner_o),
        .pending_o    (pending_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model
    bit          m_locked;
    int          m_owner;
    int          m_rr;
    bit          m_pend[NB];
    logic [MW-1:0] m_msg;
    logic [NB-1:0] m_event;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_owner  = 0;
        m_rr     = 0;
        m_msg    = '0;
        m_event  = '0;
        for (int i = 0; i < NB; i++) m_pend[i] = 0;
    endtask

    function automatic logic [NB-1:0] model_pending();
        logic [NB-1:0] v;
        v = '0;
        for (int i = 0; i < NB; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_step(input logic [NB-1:0] lk, input logic [NB-1:0] ul,
                              input logic [MW-1:0] msg);
        bit cand[NB];
        bit any;
        bit rel;
        bit granted;
        int w;
        rel = m_locked && ul[m_owner];
        any = 0;
        for (int i = 0; i < NB; i++) begin
            cand[i] = (m_pend[i] || lk[i]) && !(m_locked && i == m_owner);
            if (cand[i]) any = 1;
        end
        w = 0;
        granted = 0;
        for (int k = 0; k < NB; k++) begin
            int i;
            i = (m_rr + k) % NB;
            if (!granted && cand[i]) begin
                granted = 1;
                w = i;
            end
        end
        // Owner request is dropped unless it releases in the same cycle
        for (int i = 0; i < NB; i++)
            if (lk[i] && !(m_locked && i == m_owner && !rel)) m_pend[i] = 1;
        m_event = '0;
        if (rel) m_msg = msg;
        if (any && (!m_locked || rel)) begin
            m_locked   = 1;
            m_owner    = w;
            m_rr       = (w + 1) % NB;
            m_pend[w]  = 0;
            m_event[w] = 1'b1;
        end else if (rel) begin
            m_locked = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".locked"},  64'(locked_o),      64'(m_locked));
        check({tag, ".event"},   64'(mutex_event_o), 64'(m_event));
        check({tag, ".pending"}, 64'(pending_o),     64'(model_pending()));
        check({tag, ".msg"},     64'(msg_rdata_o),   64'(m_msg));
        if (m_locked) check({tag, ".owner"}, 64'(owner_o), 64'(m_owner));
    endtask

    // Drive one cycle of stimulus, advance model and DUT, compare after the edge
    task automatic cycle(input string tag, input logic [NB-1:0] lk, input logic [NB-1:0] ul,
                         input logic [MW-1:0] msg);
        lock_req_i   = lk;
        unlock_req_i = ul;
        msg_wdata_i  = msg;
        model_step(lk, ul, msg);
        @(posedge clk_i);
        #1;
        lock_req_i   = '0;
        unlock_req_i = '0;
        msg_wdata_i  = '0;
        compare_all(tag);
    endtask

    initial begin
        logic [NB-1:0] lk, ul;
        rst_ni       = 1'b0;
        lock_req_i   = '0;
        unlock_req_i = '0;
        msg_wdata_i  = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Reset state
        @(posedge clk_i); #1;
        check("reset.locked",  64'(locked_o),      64'd0);
        check("reset.pending", 64'(pending_o),     64'd0);
        check("reset.msg",     64'(msg_rdata_o),   64'd0);
        check("reset.event",   64'(mutex_event_o), 64'd0);
        check("reset.owner",   64'(owner_o),       64'd0);

        // Single grant from idle, then event drops
        cycle("lock3", 8'h08, 8'h00, '0);
        check("lock3.event_k", 64'(mutex_event_o), 64'h08);
        check("lock3.owner_k", 64'(owner_o),       64'd3);
        cycle("lock3.idle", 8'h00, 8'h00, '0);
        check("lock3.event_once", 64'(mutex_event_o), 64'h00);

        // Queue 1,5,6 behind owner 3; handovers follow rr order 5,6,1
        cycle("queue", 8'h62, 8'h00, '0);
        check("queue.pending_k", 64'(pending_o), 64'h62);
        cycle("hand5", 8'h00, 8'h08, 32'h1111_0005);
        check("hand5.event_k", 64'(mutex_event_o), 64'h20);
        cycle("hand6", 8'h00, 8'h20, 32'h1111_0006);
        check("hand6.event_k", 64'(mutex_event_o), 64'h40);
        cycle("hand1", 8'h00, 8'h40, 32'h1111_0001);
        check("hand1.event_k", 64'(mutex_event_o), 64'h02);
        check("hand1.locked_k", 64'(locked_o), 64'd1);

        // Release with nothing pending; message survives into next grant
        cycle("release", 8'h00, 8'h02, 32'hDEAD_BEEF);
        check("release.msg_k",    64'(msg_rdata_o), 64'hDEAD_BEEF);
        check("release.locked_k", 64'(locked_o),    64'd0);
        cycle("lock0", 8'h01, 8'h00, '0);
        check("lock0.msg_k", 64'(msg_rdata_o), 64'hDEAD_BEEF);
        cycle("free0", 8'h00, 8'h01, 32'h0000_00AA);
        cycle("lock2", 8'h04, 8'h00, '0);

        // Non-owner unlock and owner relock are ignored
        cycle("ignore", 8'h04, 8'h10, 32'h5555_5555);
        check("ignore.event_k", 64'(mutex_event_o), 64'h00);
        check("ignore.msg_k",   64'(msg_rdata_o),   64'h0000_00AA);
        // Owner unlock+lock together: free, then re-granted
        cycle("relock", 8'h04, 8'h04, 32'h0000_0BBB);
        check("relock.locked_k", 64'(locked_o), 64'd0);
        cycle("regrant", 8'h00, 8'h00, '0);
        check("regrant.event_k", 64'(mutex_event_o), 64'h04);

        // Mid-cycle async reset with pending requests
        cycle("prerst", 8'hF0, 8'h00, '0);
        check("prerst.pending_k", 64'(pending_o), 64'hF0);
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        compare_all("asyncrst");
        check("asyncrst.owner", 64'(owner_o), 64'd0);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        repeat (3) cycle("postrst", 8'h00, 8'h00, '0);

        // Random traffic, biased toward owner releases
        for (int n = 0; n < 400; n++) begin
            lk = '0;
            ul = '0;
            if ($urandom_range(0, 2) == 0) lk = NB'($urandom) & NB'($urandom);
            if (m_locked && $urandom_range(0, 2) == 0) ul[m_owner] = 1'b1;
            if ($urandom_range(0, 5) == 0) ul = ul | NB'($urandom);
            cycle("rand", lk, ul, MW'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
